multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Multicycle control FSM directly upstream of the PC update logic.
- Sequences each instruction through IF/ID/EXE/MEM/WB and decodes opcode/funct.
- Drives PCWre, Branch and Jump into the PC update block, plus datapath enables (IR, regfile, ALU, memory).
- Also keeps a retired-instruction counter for debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- op  input  6  IR[31:26], valid from ID onward
- funct  input  6  IR[5:0], valid from ID onward
- PCWre  output  1  PC update enable, one pulse per instruction
- Branch  output  1  conditional branch request; ANDed with Zero downstream
- Jump  output  1  absolute jump request
- IRWre  output  1  instruction register write enable
- RegWre  output  1  register file write enable
- RegDst  output  1  1 = rd, 0 = rt
- ALUSrcB  output  1  1 = extended immediate, 0 = rt
- ExtSel  output  1  1 = sign-extend, 0 = zero-extend
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- MemRd  output  1  data memory read
- MemWr  output  1  data memory write
- DBDataSrc  output  1  1 = memory data to writeback, 0 = ALU
- state  output  3  current FSM state
- halted  output  1  HALT state reached
- instr_cnt  output  CNT_W  retired instructions

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
- On rst: state=IF, op_q=0, funct_q=0, instr_cnt=0.
- Opcode set: R=000000, addi=001000, ori=001101, lw=100011, sw=101011, beq=000100, j=000010, halt=111111. Any other op is a NOP.
- Latching: op_q/funct_q capture op/funct on the clock edge leaving ID.
  - In the ID cycle, decode uses the live op.
  - In EXE/MEM/WB, decode uses op_q/funct_q.
- Sequences (one state per cycle):
  - R/addi/ori: IF,ID,EXE,WB
  - lw: IF,ID,EXE,MEM,WB
  - sw: IF,ID,EXE,MEM
  - beq: IF,ID,EXE
  - j and NOP: IF,ID
  - halt: IF,ID,HALT
  - The state after the last state of each sequence is IF.
- HALT is absorbing until rst. In HALT all enables are 0 and halted=1.
- Outputs are combinational (Moore-style) from state plus the live op (in ID) or op_q (later). Every signal not listed for a state is 0.
  - IF: IRWre=1.
  - ID, j: Jump=1, PCWre=1.
  - ID, NOP: PCWre=1.
  - EXE: ALUSrcB=1 for addi/ori/lw/sw. ExtSel=1 for addi/lw/sw/beq.
  - EXE, R-type: ALUOp from funct_q: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct = add.
  - EXE, ori: ALUOp=or.
  - EXE, beq: ALUOp=sub, Branch=1, PCWre=1.
  - MEM, lw: MemRd=1, ALUSrcB=1, ExtSel=1.
  - MEM, sw: MemWr=1, PCWre=1, ALUSrcB=1, ExtSel=1.
  - WB: RegWre=1 and PCWre=1. RegDst=1 only for R-type. DBDataSrc=1 only for lw. ALUOp/ALUSrcB/ExtSel are held at their EXE values.
- Exactly one PCWre-high cycle per non-halt instruction.
- instr_cnt increments on each rising edge where PCWre=1 and wraps modulo 2^CNT_W. It does not count halt.
- Branch and Jump are never both 1 in the same cycle.
- rst asserted mid-instruction aborts immediately: next state IF, no partial PCWre or RegWre.

Test Plan:
- Reset release, op=000000 funct=100000 (add) -> states 000,001,010,100,000; RegWre=1 and PCWre=1 only in WB; RegDst=1; ALUOp=000; instr_cnt=1.
- lw (op=100011) -> 5-cycle sequence; MemRd=1 in MEM; DBDataSrc=1 and RegWre=1 in WB; sw (101011) -> 4 cycles, MemWr=1 and PCWre=1 in MEM, RegWre never 1.
- beq (000100) -> 3 cycles; EXE has Branch=1, PCWre=1, ALUOp=001, ExtSel=1. j (000010) -> 2 cycles; ID has Jump=1, PCWre=1, Branch=0.
- Unknown op 010101 -> 2-cycle NOP with PCWre in ID; R-type funct 111111 -> ALUOp=000.
- halt (111111) after 3 instructions -> state=111, halted=1, instr_cnt stays 3 for 20 cycles with all enables 0; rst -> state=000.
- rst pulsed during MEM of lw -> state=000 asynchronously, RegWre never asserted, instr_cnt=0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multicycle IF/ID/EXE/MEM/WB control FSM with opcode/funct
// decode, PC update requests, datapath enables and a retired-instruction counter.
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic             PCWre,
  output logic             Branch,
  output logic             Jump,
  output logic             IRWre,
  output logic             RegWre,
  output logic             RegDst,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       ALUOp,
  output logic             MemRd,
  output logic             MemWr,
  output logic             DBDataSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  state_e           state_q, state_d;
  logic [5:0]       op_q, funct_q, opc;
  logic [CNT_W-1:0] cnt_q;
  logic             is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt, is_nop, ex;
  logic [2:0]       alu_r, alu;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q    <= op;
        funct_q <= funct;
      end
      if (PCWre) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  // ID decodes the live opcode; later states use the copy latched on leaving ID
  assign opc     = (state_q == S_ID) ? op : op_q;
  assign is_r    = opc == OP_R;
  assign is_addi = opc == OP_ADDI;
  assign is_ori  = opc == OP_ORI;
  assign is_lw   = opc == OP_LW;
  assign is_sw   = opc == OP_SW;
  assign is_beq  = opc == OP_BEQ;
  assign is_j    = opc == OP_J;
  assign is_halt = opc == OP_HALT;
  assign is_nop  = !(is_r | is_addi | is_ori | is_lw | is_sw | is_beq | is_j | is_halt);
  assign alu_r = (funct_q == 6'b100010) ? 3'b001 :
                 (funct_q == 6'b100100) ? 3'b010 :
                 (funct_q == 6'b100101) ? 3'b011 :
                 (funct_q == 6'b101010) ? 3'b100 : 3'b000;
  assign alu   = is_r ? alu_r : is_ori ? 3'b011 : is_beq ? 3'b001 : 3'b000;
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID:   state_d = is_halt ? S_HALT : (is_j | is_nop) ? S_IF : S_EXE;
      S_EXE:  state_d = (is_lw | is_sw) ? S_MEM : is_beq ? S_IF : S_WB;
      S_MEM:  state_d = is_lw ? S_WB : S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end
  // EXE choices stay on the datapath through MEM and WB
  assign ex        = (state_q == S_EXE) | (state_q == S_MEM) | (state_q == S_WB);
  assign IRWre     = state_q == S_IF;
  assign Jump      = (state_q == S_ID) & is_j;
  assign Branch    = (state_q == S_EXE) & is_beq;
  assign PCWre     = ((state_q == S_ID) & (is_j | is_nop)) | Branch |
                     ((state_q == S_MEM) & is_sw) | (state_q == S_WB);
  assign ALUSrcB   = ex & (is_addi | is_ori | is_lw | is_sw);
  assign ExtSel    = ex & (is_addi | is_lw | is_sw | is_beq);
  assign ALUOp     = ex ? alu : 3'b000;
  assign MemRd     = (state_q == S_MEM) & is_lw;
  assign MemWr     = (state_q == S_MEM) & is_sw;
  assign RegWre    = state_q == S_WB;
  assign RegDst    = (state_q == S_WB) & is_r;
  assign DBDataSrc = (state_q == S_WB) & is_lw;
  assign halted    = state_q == S_HALT;
  assign state     = state_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed instruction sequences with hand-computed control vectors.
module tb_multi_cycle_ctrl;
  logic        clk, rst;
  logic [5:0]  op, funct;
  logic        PCWre, Branch, Jump, IRWre, RegWre, RegDst, ALUSrcB, ExtSel;
  logic        MemRd, MemWr, DBDataSrc, halted;
  logic [2:0]  ALUOp, state;
  logic [31:0] instr_cnt;
  logic [14:0] ctl;
  int          checks = 0;
  int          fails = 0;
  // ctl = {PCWre,Branch,Jump,IRWre, RegWre,RegDst,ALUSrcB,ExtSel, ALUOp, MemRd,MemWr,DBDataSrc,halted}
  localparam logic [14:0] C_IF = 15'b00010000_000_0000;
  localparam logic [14:0] C_0  = 15'b00000000_000_0000;
  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .PCWre(PCWre), .Branch(Branch), .Jump(Jump), .IRWre(IRWre),
    .RegWre(RegWre), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .ALUOp(ALUOp), .MemRd(MemRd), .MemWr(MemWr), .DBDataSrc(DBDataSrc),
    .state(state), .halted(halted), .instr_cnt(instr_cnt)
  );
  assign ctl = {PCWre, Branch, Jump, IRWre, RegWre, RegDst, ALUSrcB, ExtSel,
                ALUOp, MemRd, MemWr, DBDataSrc, halted};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [2:0] st, input logic [14:0] c);
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " ctl"}, 32'(ctl), 32'(c));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; op = 6'h00; funct = 6'h00;
    @(posedge clk);
    #1;
    chk("reset state", 32'(state), 0);
    chk("reset cnt", instr_cnt, 0);
    chk("reset ctl", 32'(ctl), 32'(C_IF));
    rst = 0;
    op = 6'b000000; funct = 6'b100000;
    step("add IF", 3'b000, C_IF);
    step("add ID", 3'b001, C_0);
    op = 6'b101010; funct = 6'b000000;
    step("add EXE", 3'b010, C_0);
    step("add WB", 3'b100, 15'b10001100_000_0000);
    chk("cnt after add", instr_cnt, 1);
    op = 6'b100011;
    step("lw IF", 3'b000, C_IF);
    step("lw ID", 3'b001, C_0);
    op = 6'b101010;
    step("lw EXE", 3'b010, 15'b00000011_000_0000);
    step("lw MEM", 3'b011, 15'b00000011_000_1000);
    step("lw WB", 3'b100, 15'b10001011_000_0010);
    op = 6'b101011;
    step("sw IF", 3'b000, C_IF);
    step("sw ID", 3'b001, C_0);
    op = 6'b101010;
    step("sw EXE", 3'b010, 15'b00000011_000_0000);
    step("sw MEM", 3'b011, 15'b10000011_000_0100);
    chk("cnt after sw", instr_cnt, 3);
    op = 6'b000100;
    step("beq IF", 3'b000, C_IF);
    step("beq ID", 3'b001, C_0);
    op = 6'b101010;
    step("beq EXE", 3'b010, 15'b11000001_001_0000);
    op = 6'b000010;
    step("j IF", 3'b000, C_IF);
    step("j ID", 3'b001, 15'b10100000_000_0000);
    op = 6'b010101;
    step("nop IF", 3'b000, C_IF);
    step("nop ID", 3'b001, 15'b10000000_000_0000);
    chk("cnt after nop", instr_cnt, 6);
    op = 6'b000000; funct = 6'b111111;
    step("rff IF", 3'b000, C_IF);
    step("rff ID", 3'b001, C_0);
    step("rff EXE", 3'b010, C_0);
    step("rff WB", 3'b100, 15'b10001100_000_0000);
    op = 6'b000000; funct = 6'b100010;
    step("sub IF", 3'b000, C_IF);
    step("sub ID", 3'b001, C_0);
    op = 6'b101010; funct = 6'b100000;
    step("sub EXE", 3'b010, 15'b00000000_001_0000);
    step("sub WB", 3'b100, 15'b10001100_001_0000);
    op = 6'b000000; funct = 6'b101010;
    step("slt IF", 3'b000, C_IF);
    step("slt ID", 3'b001, C_0);
    step("slt EXE", 3'b010, 15'b00000000_100_0000);
    step("slt WB", 3'b100, 15'b10001100_100_0000);
    funct = 6'b100100;
    step("and IF", 3'b000, C_IF);
    step("and ID", 3'b001, C_0);
    step("and EXE", 3'b010, 15'b00000000_010_0000);
    step("and WB", 3'b100, 15'b10001100_010_0000);
    funct = 6'b100101;
    step("or IF", 3'b000, C_IF);
    step("or ID", 3'b001, C_0);
    step("or EXE", 3'b010, 15'b00000000_011_0000);
    step("or WB", 3'b100, 15'b10001100_011_0000);
    op = 6'b001000;
    step("addi IF", 3'b000, C_IF);
    step("addi ID", 3'b001, C_0);
    op = 6'b101010;
    step("addi EXE", 3'b010, 15'b00000011_000_0000);
    step("addi WB", 3'b100, 15'b10001011_000_0000);
    op = 6'b001101;
    step("ori IF", 3'b000, C_IF);
    step("ori ID", 3'b001, C_0);
    op = 6'b101010;
    step("ori EXE", 3'b010, 15'b00000010_011_0000);
    step("ori WB", 3'b100, 15'b10001010_011_0000);
    chk("cnt after ori", instr_cnt, 13);
    op = 6'b100011;
    step("lwr IF", 3'b000, C_IF);
    step("lwr ID", 3'b001, C_0);
    step("lwr EXE", 3'b010, 15'b00000011_000_0000);
    chk("lwr MEM state", 32'(state), 3);
    #2 rst = 1;
    #1;
    chk("async rst state", 32'(state), 0);
    chk("async rst cnt", instr_cnt, 0);
    chk("async rst ctl", 32'(ctl), 32'(C_IF));
    @(posedge clk);
    #1;
    chk("held rst state", 32'(state), 0);
    chk("held rst RegWre", 32'(RegWre), 0);
    rst = 0;
    op = 6'b000010;
    step("j2 IF", 3'b000, C_IF);
    step("j2 ID", 3'b001, 15'b10100000_000_0000);
    op = 6'b010101;
    step("nop2 IF", 3'b000, C_IF);
    step("nop2 ID", 3'b001, 15'b10000000_000_0000);
    op = 6'b000100;
    step("beq2 IF", 3'b000, C_IF);
    step("beq2 ID", 3'b001, C_0);
    step("beq2 EXE", 3'b010, 15'b11000001_001_0000);
    op = 6'b111111;
    step("halt IF", 3'b000, C_IF);
    step("halt ID", 3'b001, C_0);
    op = 6'b000010;
    for (int i = 0; i < 20; i++) begin
      chk("halt cnt", instr_cnt, 3);
      step("halt", 3'b111, 15'b00000000_000_0001);
    end
    rst = 1;
    #1;
    chk("halt rst state", 32'(state), 0);
    chk("halt rst halted", 32'(halted), 0);
    rst = 0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
